// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: input ports, output registers, button event flags with an IRQ,
// and a single-pixel framebuffer write port with optional address auto-increment.
module mmio_io_hub #(
  parameter logic [31:0] BASE_AD  = 32'h11000000,
  parameter logic [31:0] STRIDE   = 32'h20,
  parameter int          NUM_IN   = 2,
  parameter int          IN_W     = 16,
  parameter int          NUM_OUT  = 2,
  parameter int          OUT_W    = 16,
  parameter int          NUM_BTN  = 4,
  parameter int          FB_AW    = 13,
  parameter int          FB_DEPTH = 4800
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [31:0]              IOBUS_ADDR,
  input  logic [31:0]              IOBUS_OUT,
  input  logic                     IOBUS_WR,
  output logic [31:0]              IOBUS_IN,
  input  logic [NUM_IN*IN_W-1:0]   IN_DATA,
  output logic [NUM_OUT*OUT_W-1:0] OUT_DATA,
  input  logic [NUM_BTN-1:0]       BTN,
  output logic                     IRQ,
  output logic [FB_AW-1:0]         FB_WA,
  output logic [7:0]               FB_WD,
  output logic                     FB_WE,
  input  logic [7:0]               FB_RD
);

  localparam int EVT_SLOT  = NUM_IN + NUM_OUT;
  localparam int FBA_SLOT  = EVT_SLOT + 1;
  localparam int FBD_SLOT  = EVT_SLOT + 2;
  localparam int CTRL_SLOT = EVT_SLOT + 3;
  localparam int NUM_SLOTS = EVT_SLOT + 4;

  logic                     hit;
  int                       slot;
  logic                     wr_evt, wr_fba, wr_fbd, wr_ctrl, fba_ok;
  logic [NUM_OUT*OUT_W-1:0] out_q;
  logic [NUM_BTN-1:0]       btn_q, evt_q;
  logic [NUM_BTN:0]         ctrl_q;
  logic [FB_AW-1:0]         fb_wa;
  logic [7:0]               fb_wd;
  logic                     fb_we, inc_pend;
  logic [31:0]              rd;

  // Exact-match decode: only addresses landing precisely on a slot boundary select it.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    hit  = 1'b0;
    slot = 0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (IOBUS_ADDR == BASE_AD + 32'(k) * STRIDE) begin
        hit  = 1'b1;
        slot = k;
      end
    end
  end

  assign wr_evt  = IOBUS_WR && hit && (slot == EVT_SLOT);
  assign wr_fba  = IOBUS_WR && hit && (slot == FBA_SLOT);
  assign wr_fbd  = IOBUS_WR && hit && (slot == FBD_SLOT);
  assign wr_ctrl = IOBUS_WR && hit && (slot == CTRL_SLOT);
  assign fba_ok  = IOBUS_OUT < 32'(FB_DEPTH);

  always_ff @(posedge CLK) begin
    // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge only.
    if (!RST_N) begin
      out_q <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (IOBUS_WR && hit && (slot == NUM_IN + j))
          out_q[j*OUT_W +: OUT_W] <= IOBUS_OUT[OUT_W-1:0];
      end
    end
  end

  // History loads live BTN in reset so buttons held through reset raise no event.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      btn_q  <= BTN;
      evt_q  <= '0;
      ctrl_q <= '0;
    end else begin
      btn_q <= BTN;
      evt_q <= (evt_q & ~(wr_evt ? IOBUS_OUT[NUM_BTN-1:0] : '0)) | (BTN & ~btn_q);
      if (wr_ctrl) ctrl_q <= IOBUS_OUT[NUM_BTN:0];
    end
  end

  assign IRQ = |(evt_q & ctrl_q[NUM_BTN:1]);

  // Increment lands one cycle after the write pulse so the pulse sees a stable address.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fb_wa    <= '0;
      fb_wd    <= '0;
      fb_we    <= 1'b0;
      inc_pend <= 1'b0;
    end else begin
      fb_we    <= wr_fbd;
      inc_pend <= wr_fbd && ctrl_q[0];
      if (wr_fbd) fb_wd <= IOBUS_OUT[7:0];
      if (wr_fba && fba_ok)
        fb_wa <= IOBUS_OUT[FB_AW-1:0];
      else if (inc_pend)
        fb_wa <= (fb_wa == FB_AW'(FB_DEPTH - 1)) ? '0 : fb_wa + 1'b1;
    end
  end

  assign OUT_DATA = out_q;
  assign FB_WA    = fb_wa;
  assign FB_WD    = fb_wd;
  assign FB_WE    = fb_we;

  always_comb begin
    rd = '0;
    if (hit) begin
      for (int i = 0; i < NUM_IN; i++)
        if (slot == i) rd = 32'(IN_DATA[i*IN_W +: IN_W]);
      for (int j = 0; j < NUM_OUT; j++)
        if (slot == NUM_IN + j) rd = 32'(out_q[j*OUT_W +: OUT_W]);
      if (slot == EVT_SLOT)  rd = 32'(evt_q);
      if (slot == FBA_SLOT)  rd = 32'(fb_wa);
      if (slot == FBD_SLOT)  rd = {24'b0, FB_RD};
      if (slot == CTRL_SLOT) rd = 32'(ctrl_q);
    end
  end

  assign IOBUS_IN = rd;

endmodule

// File: tb/tb_mmio_io_hub.sv
// Bench for mmio_io_hub: directed scenarios plus randomized bus traffic checked
// against a transaction-level model of the slot map, event flags and pixel port.
module tb_mmio_io_hub;

  localparam logic [31:0] BASE  = 32'h11000000;
  localparam logic [31:0] STR   = 32'h20;
  localparam int          NI    = 2;
  localparam int          IW    = 16;
  localparam int          NO    = 2;
  localparam int          OW    = 16;
  localparam int          NB    = 4;
  localparam int          AW    = 13;
  localparam int          DEPTH = 4800;
  localparam int          E     = NI + NO;
  localparam int          NSLOT = E + 4;

  logic              CLK, RST_N;
  logic [31:0]       IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;
  logic              IOBUS_WR;
  logic [NI*IW-1:0]  IN_DATA;
  logic [NO*OW-1:0]  OUT_DATA;
  logic [NB-1:0]     BTN;
  logic              IRQ;
  logic [AW-1:0]     FB_WA;
  logic [7:0]        FB_WD, FB_RD;
  logic              FB_WE;

  mmio_io_hub dut (
    .CLK(CLK), .RST_N(RST_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .IN_DATA(IN_DATA), .OUT_DATA(OUT_DATA),
    .BTN(BTN), .IRQ(IRQ), .FB_WA(FB_WA), .FB_WD(FB_WD), .FB_WE(FB_WE), .FB_RD(FB_RD)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [OW-1:0] m_out [NO];
  logic [NB-1:0] m_evt, m_prev;
  logic [NB:0]   m_ctrl;
  int            m_wa;
  logic [7:0]    m_wd;
  logic          m_we, m_inc;

  function automatic logic [31:0] sa(input int k);
    return BASE + 32'(k) * STR;
  endfunction

  function automatic int slot_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off % STR != 0) return -1;
    if (off / STR >= NSLOT) return -1;
    return int'(off / STR);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int s;
    s = slot_of(a);
    if (s < 0)       return 32'h0;
    if (s < NI)      return 32'(IN_DATA[s*IW +: IW]);
    if (s < E)       return 32'(m_out[s-NI]);
    if (s == E)      return 32'(m_evt);
    if (s == E + 1)  return 32'(m_wa);
    if (s == E + 2)  return {24'b0, FB_RD};
    return 32'(m_ctrl);
  endfunction

  // Advance one clock: update the model from the inputs seen at the edge, then compare.
  task automatic tick();
    int s;
    s = IOBUS_WR ? slot_of(IOBUS_ADDR) : -1;
    if (!RST_N) begin
      for (int j = 0; j < NO; j++) m_out[j] = '0;
      m_evt = '0; m_ctrl = '0; m_wa = 0; m_wd = '0; m_we = 1'b0; m_inc = 1'b0;
      m_prev = BTN;
    end else begin
      if (s >= NI && s < E) m_out[s-NI] = IOBUS_OUT[OW-1:0];
      if (s == E) m_evt = m_evt & ~IOBUS_OUT[NB-1:0];
      m_evt  = m_evt | (BTN & ~m_prev);
      m_prev = BTN;
      if (m_inc) m_wa = (m_wa + 1) % DEPTH;
      if (s == E + 1 && IOBUS_OUT < 32'(DEPTH)) m_wa = int'(IOBUS_OUT);
      m_we  = (s == E + 2);
      m_inc = (s == E + 2) && m_ctrl[0];
      if (s == E + 2) m_wd = IOBUS_OUT[7:0];
      if (s == E + 3) m_ctrl = IOBUS_OUT[NB:0];
    end
    @(posedge CLK);
    #1;
    for (int j = 0; j < NO; j++) check($sformatf("out%0d", j), 32'(OUT_DATA[j*OW +: OW]), 32'(m_out[j]));
    check("irq", 32'(IRQ), 32'(|(m_evt & m_ctrl[NB:1])));
    check("fb_wa", 32'(FB_WA), 32'(m_wa));
    check("fb_we", 32'(FB_WE), 32'(m_we));
    check("fb_wd", 32'(FB_WD), 32'(m_wd));
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = 1'b1;
    tick();
    IOBUS_WR = 1'b0; IOBUS_ADDR = 32'h0; IOBUS_OUT = 32'h0;
  endtask

  task automatic bus_rd(input string tag, input logic [31:0] a);
    IOBUS_ADDR = a;
    #1;
    check(tag, IOBUS_IN, model_rd(a));
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    IOBUS_ADDR = a;
    #1;
    check(tag, IOBUS_IN, exp);
  endtask

  initial begin
    RST_N = 1'b0; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0;
    IN_DATA = 32'h1234_ABCD; BTN = '0; FB_RD = 8'h5C;
    #2;
    tick(); tick();
    check("rst_out", 32'(OUT_DATA), 32'h0);
    check("rst_fbwa", 32'(FB_WA), 32'h0);
    RST_N = 1'b1;
    tick();

    // Output register write/readback, input ports, unmapped address
    bus_wr(sa(NI), 32'hDEAD_BEEF);
    check("out0_beef", 32'(OUT_DATA[OW-1:0]), 32'h0000_BEEF);
    rd_expect("rd_out0", sa(NI), 32'h0000_BEEF);
    rd_expect("rd_unmapped", BASE + 32'd4, 32'h0);
    rd_expect("rd_in1", sa(1), 32'h0000_1234);
    rd_expect("rd_fbd", sa(E + 2), 32'h0000_005C);
    bus_wr(sa(0), 32'hFFFF_FFFF);
    rd_expect("in_wr_ignored", sa(0), 32'h0000_ABCD);

    // Event flags, mask, W1C, set-beats-clear
    bus_wr(sa(E + 3), 32'h8);
    BTN = 4'b0100;
    tick();
    rd_expect("evt_set", sa(E), 32'h4);
    check("irq_on", 32'(IRQ), 32'h1);
    bus_wr(sa(E), 32'h4);
    rd_expect("evt_clr", sa(E), 32'h0);
    check("irq_off", 32'(IRQ), 32'h0);
    BTN = 4'b0000;
    tick();
    BTN = 4'b0100;
    bus_wr(sa(E), 32'h4);
    rd_expect("evt_set_wins", sa(E), 32'h4);
    bus_wr(sa(E), 32'hF);
    rd_expect("rd_ctrl", sa(E + 3), 32'h8);

    // Auto-increment across the wrap point with back-to-back pixel writes
    bus_wr(sa(E + 3), 32'h9);
    bus_wr(sa(E + 1), 32'd4798);
    IOBUS_ADDR = sa(E + 2); IOBUS_WR = 1'b1;
    IOBUS_OUT = 32'h11; tick();
    check("px0_we", 32'(FB_WE), 32'h1); check("px0_wa", 32'(FB_WA), 32'd4798);
    IOBUS_OUT = 32'h22; tick();
    check("px1_we", 32'(FB_WE), 32'h1); check("px1_wa", 32'(FB_WA), 32'd4799);
    check("px1_wd", 32'(FB_WD), 32'h22);
    IOBUS_OUT = 32'h33; tick();
    check("px2_we", 32'(FB_WE), 32'h1); check("px2_wa", 32'(FB_WA), 32'd0);
    IOBUS_WR = 1'b0; tick();
    check("px_end_we", 32'(FB_WE), 32'h0);
    rd_expect("fba_final", sa(E + 1), 32'd1);

    // Out-of-range address, FBA priority over increment, no-autoinc pulse
    bus_wr(sa(E + 1), 32'd5000);
    check("fba_5000", 32'(FB_WA), 32'd1);
    bus_wr(sa(E + 1), 32'd4800);
    check("fba_4800", 32'(FB_WA), 32'd1);
    bus_wr(sa(E + 2), 32'h77);
    bus_wr(sa(E + 1), 32'd100);
    check("fba_prio", 32'(FB_WA), 32'd100);
    tick();
    check("fba_prio_hold", 32'(FB_WA), 32'd100);
    bus_wr(sa(E + 3), 32'h0);
    bus_wr(sa(E + 2), 32'h5A);
    check("noinc_we", 32'(FB_WE), 32'h1); check("noinc_wa", 32'(FB_WA), 32'd100);
    tick();
    check("noinc_we_end", 32'(FB_WE), 32'h0); check("noinc_wa_hold", 32'(FB_WA), 32'd100);

    // Held button through reset; reset against a concurrent pixel write
    BTN = 4'b0001;
    RST_N = 1'b0; tick(); tick();
    RST_N = 1'b1; tick();
    rd_expect("evt_after_rst", sa(E), 32'h0);
    bus_wr(sa(E + 3), 32'h1);
    bus_wr(sa(E + 1), 32'd50);
    IOBUS_ADDR = sa(E + 2); IOBUS_OUT = 32'h99; IOBUS_WR = 1'b1; RST_N = 1'b0;
    tick();
    check("rst_wr_we", 32'(FB_WE), 32'h0); check("rst_wr_wa", 32'(FB_WA), 32'h0);
    IOBUS_WR = 1'b0; RST_N = 1'b1;
    tick();
    check("rst_no_inc", 32'(FB_WA), 32'h0);

    // Randomized traffic against the model
    for (int it = 0; it < 600; it++) begin
      int op, k;
      logic [31:0] d;
      IN_DATA = $urandom;
      FB_RD = 8'($urandom);
      if ($urandom_range(0, 3) == 0) BTN = NB'($urandom);
      op = $urandom_range(0, 4);
      k  = $urandom_range(0, NSLOT - 1);
      case (op)
        0, 1: begin
          d = (k == E + 1) ? 32'($urandom_range(0, 5200)) : $urandom;
          if (k == E && $urandom_range(0, 1) == 0) d = 32'hF;
          bus_wr(sa(k), d);
        end
        2: bus_rd("rnd_rd", sa(k));
        3: bus_rd("rnd_unmapped", sa(k) + 32'($urandom_range(1, 31)));
        default: tick();
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
